// File: rtl/cdc_request_arbiter.sv
// cdc_request_arbiter: round-robin arbiter sharing one synchronized receive path among
// NUM_REQ asynchronous 4-phase req/ack sources, delivering words on a valid/ready stream.
module cdc_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         src_req,
  input  logic [NUM_REQ*WIDTH-1:0]   src_data,
  output logic [NUM_REQ-1:0]         src_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q;
  logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0] req_s, cand, ack_q, ack_d;
  logic [IW-1:0] ptr_q, src_q, g;
  logic [IW:0] idx;
  logic found, valid_q;
  logic [WIDTH-1:0] data_q;
  assign req_s = sync_q[SYNC_STAGES-1];
  assign cand = req_s & ~ack_q;
  // Search starts just after the last granted channel and wraps modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    g = ptr_q;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_REQ) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (!found && cand[IW'(idx)]) begin
        found = 1'b1;
        g = IW'(idx);
      end
    end
  end
  // Ack drops once the source's synchronized req is seen low; set on the output handshake.
  always_comb begin
    ack_d = ack_q & req_s;
    if (state_q == SEND && out_ready) ack_d[src_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      state_q <= IDLE;
    end else begin
      sync_q[0] <= src_req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      ack_q <= ack_d;
      if (state_q == IDLE && found) begin
        data_q  <= src_data[int'(g)*WIDTH +: WIDTH];
        src_q   <= g;
        ptr_q   <= g;
        valid_q <= 1'b1;
        state_q <= SEND;
      end else if (state_q == SEND && out_ready) begin
        valid_q <= 1'b0;
        state_q <= IDLE;
      end
    end
  end
  assign src_ack   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign busy      = state_q == SEND || |ack_q;
endmodule
